tt_sweep_checker: RTL and testbench

Parametrised truth-table function block with a built-in exhaustive sweep checker. It is the next generation of the fixed 3-input lab function: the implemented function is a programmable N-input truth table rather than fixed logic. It can be driven manually one input vector at a time, or it can sweep all 2^N input combinations itself and check each result against a golden table. It sits between the lab stimulus logic and the pass/fail indicators, replacing per-function hand-written benches.

---
 rtl/tt_sweep_checker_pkg.sv | 18 +
 rtl/tt_sweep_checker_if.sv | 33 +++
 rtl/tt_sweep_checker_lut.sv | 23 ++
 rtl/tt_sweep_checker.sv | 122 ++++++++++++
 tb/tb_tt_sweep_checker.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker.
//   state_t  : FSM state encoding (IDLE, LOAD, SWEEP, DRAIN, DONE; 3-bit)
//   tt_width : number of truth-table entries for an N-input function (2^N)
package tt_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SWEEP = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Bus bundle between the lab stimulus logic and the sweep checker.
//   master : stimulus side (drives start, man_in, func_tt, gold_tt)
//   slave  : checker side (drives in_vec, f, busy, done, pass, err_cnt,
//            first_err_idx)
interface tt_sweep_checker_if
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 3
);

  logic                      start;
  logic [N_IN-1:0]           man_in;
  logic [tt_width(N_IN)-1:0] func_tt;
  logic [tt_width(N_IN)-1:0] gold_tt;
  logic [N_IN-1:0]           in_vec;
  logic                      f;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic [N_IN:0]             err_cnt;
  logic [N_IN-1:0]           first_err_idx;

  modport master (
    output start, man_in, func_tt, gold_tt,
    input  in_vec, f, busy, done, pass, err_cnt, first_err_idx
  );

  modport slave (
    input  start, man_in, func_tt, gold_tt,
    output in_vec, f, busy, done, pass, err_cnt, first_err_idx
  );

endinterface

// File: rtl/tt_sweep_checker_lut.sv
// Registered truth-table mux: f <= tt[in_vec] on every rising edge.
//   clk, rst_n : clock, synchronous active-low reset (f clears to 0)
//   tt         : 2^N_IN-entry truth table, bit i = f for input i
//   in_vec     : table index
//   f          : registered table output
module tt_lut
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [tt_width(N_IN)-1:0] tt,
  input  logic [N_IN-1:0]           in_vec,
  output logic                      f
);

  always_ff @(posedge clk) begin
    if (!rst_n) f <= 1'b0;
    else        f <= tt[in_vec];
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Programmable N-input truth-table function with built-in exhaustive sweep
// checker. In IDLE the registered input vector follows man_in and f follows
// the live func_tt. A start request snapshots func_tt/gold_tt, steps every
// input combination through the same LUT, and counts mismatches against the
// golden table.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of tt_sweep_checker_if (start, man_in, func_tt,
//                gold_tt in; in_vec, f, busy, done, pass, err_cnt,
//                first_err_idx out)
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_sweep_checker_if.slave bus
);

  localparam int unsigned TW = tt_width(N_IN);

  state_t          state, state_nx;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] in_vec_q;
  logic [TW-1:0]   func_sh, gold_sh;
  logic [TW-1:0]   lut_tt;
  logic            f_lut;
  logic            vec_valid, f_valid;
  logic [N_IN-1:0] f_idx;
  logic            mismatch;
  logic [N_IN:0]   err_q, err_nx;
  logic [N_IN-1:0] first_q;
  logic            pass_q, busy_q, done_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = LOAD;
      LOAD:    state_nx = SWEEP;
      SWEEP:   if (idx == '1) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Manual mode uses the live table; everything else uses the snapshot so
  // table edits after LOAD cannot disturb the sweep.
  always_comb begin
    lut_tt   = (state == IDLE) ? bus.func_tt : func_sh;
    mismatch = f_valid && (f_lut != gold_sh[f_idx]);
    err_nx   = err_q + (N_IN + 1)'(mismatch);
  end

  tt_lut #(.N_IN(N_IN)) u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tt     (lut_tt),
    .in_vec (in_vec_q),
    .f      (f_lut)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      in_vec_q  <= '0;
      func_sh   <= '0;
      gold_sh   <= '0;
      vec_valid <= 1'b0;
      f_valid   <= 1'b0;
      f_idx     <= '0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
      done_q <= (state == DONE);

      // valid/index travel one stage behind in_vec so they line up with f
      vec_valid <= (state == SWEEP);
      f_valid   <= vec_valid;
      f_idx     <= in_vec_q;

      if (mismatch) begin
        err_q <= err_nx;
        if (err_q == '0) first_q <= f_idx;
      end

      case (state)
        IDLE: in_vec_q <= bus.man_in;
        LOAD: begin
          func_sh <= bus.func_tt;
          gold_sh <= bus.gold_tt;
          err_q   <= '0;
          first_q <= '0;
          pass_q  <= 1'b0;
          idx     <= '0;
        end
        SWEEP: begin
          in_vec_q <= idx;
          idx      <= idx + 1'b1;
        end
        // the last compare retires on this same edge, so use err_nx
        DONE: pass_q <= (err_nx == '0);
        default: ;
      endcase
    end
  end

  assign bus.in_vec        = in_vec_q;
  assign bus.f             = f_lut;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic pass;
    int   err;
    int   first;
    int   done_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] func;
    logic [7:0] gold;
    logic       pass;
    int         err;
    int         first;
  } vec_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t q8[$];

  tt_sweep_checker_if #(.N_IN(1)) b1();
  tt_sweep_checker_if #(.N_IN(3)) b3();
  tt_sweep_checker_if #(.N_IN(8)) b8();

  tt_sweep_checker #(.N_IN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  tt_sweep_checker #(.N_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  tt_sweep_checker #(.N_IN(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // scoreboard monitors: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (b1.done) begin
      if (q1.size() == 0) chk("n1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("n1_done_cycle", cyc, e.done_cyc);
        chk("n1_pass", b1.pass, e.pass);
        chk("n1_err_cnt", b1.err_cnt, e.err);
        chk("n1_first_err_idx", b1.first_err_idx, e.first);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b3.done) begin
      if (q3.size() == 0) chk("n3_unexpected_done", 1, 0);
      else begin
        e = q3.pop_front();
        chk("n3_done_cycle", cyc, e.done_cyc);
        chk("n3_pass", b3.pass, e.pass);
        chk("n3_err_cnt", b3.err_cnt, e.err);
        chk("n3_first_err_idx", b3.first_err_idx, e.first);
        chk("n3_busy_at_done", b3.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b8.done) begin
      if (q8.size() == 0) chk("n8_unexpected_done", 1, 0);
      else begin
        e = q8.pop_front();
        chk("n8_done_cycle", cyc, e.done_cyc);
        chk("n8_pass", b8.pass, e.pass);
        chk("n8_err_cnt", b8.err_cnt, e.err);
        chk("n8_first_err_idx", b8.first_err_idx, e.first);
      end
    end
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_all(input int limit);
    int n;
    n = 0;
    while ((q1.size() + q3.size() + q8.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("scoreboard_timeout", q1.size() + q3.size() + q8.size(), 0);
  endtask

  // one full N=3 sweep from IDLE, also tracking the applied input vectors
  task automatic sweep3(input logic [7:0] fn, input logic [7:0] gd,
                        input logic ep, input int ee, input int ef);
    int e;
    b3.func_tt = fn;
    b3.gold_tt = gd;
    b3.start   = 1'b1;
    e = cyc + 1;
    q3.push_back('{pass: ep, err: ee, first: ef, done_cyc: e + 11});
    @(negedge clk);
    b3.start = 1'b0;
    chk("n3_busy_after_start", b3.busy, 1);
    for (int k = 0; k < 8; k++) begin
      wait_to(e + 2 + k);
      chk("n3_in_vec_step", b3.in_vec, k);
    end
    wait_all(40);
  endtask

  vec_t tbl[7];

  initial begin
    int e;

    tbl[0] = '{func: 8'hE8, gold: 8'hE8, pass: 1'b1, err: 0, first: 0};
    tbl[1] = '{func: 8'hE8, gold: 8'hE9, pass: 1'b0, err: 1, first: 0};
    tbl[2] = '{func: 8'h0F, gold: 8'hFF, pass: 1'b0, err: 4, first: 4};
    tbl[3] = '{func: 8'h00, gold: 8'hFF, pass: 1'b0, err: 8, first: 0};
    tbl[4] = '{func: 8'hA5, gold: 8'h5A, pass: 1'b0, err: 8, first: 0};
    tbl[5] = '{func: 8'h3C, gold: 8'h34, pass: 1'b0, err: 1, first: 3};
    tbl[6] = '{func: 8'h80, gold: 8'h00, pass: 1'b0, err: 1, first: 7};

    b1.start = 1'b0; b1.man_in = '0; b1.func_tt = '0; b1.gold_tt = '0;
    b8.start = 1'b0; b8.man_in = '0; b8.func_tt = '0; b8.gold_tt = '0;
    b3.start = 1'b0; b3.man_in = 3'b110; b3.func_tt = 8'hFF; b3.gold_tt = 8'h00;

    // reset values, with inputs that would otherwise make outputs nonzero
    repeat (3) @(negedge clk);
    chk("rst_in_vec", b3.in_vec, 0);
    chk("rst_f", b3.f, 0);
    chk("rst_busy", b3.busy, 0);
    chk("rst_done", b3.done, 0);
    chk("rst_pass", b3.pass, 0);
    chk("rst_err_cnt", b3.err_cnt, 0);
    chk("rst_first_err_idx", b3.first_err_idx, 0);

    // manual mode
    rst_n = 1'b1;
    b3.func_tt = 8'h20;
    b3.man_in  = 3'b101;
    @(negedge clk);
    chk("man_in_vec_1edge", b3.in_vec, 5);
    @(negedge clk);
    chk("man_f_2edge", b3.f, 1);
    b3.man_in = 3'b100;
    @(negedge clk);
    chk("man_in_vec_next", b3.in_vec, 4);
    chk("man_f_lag", b3.f, 1);
    @(negedge clk);
    chk("man_f_next", b3.f, 0);

    // table-driven sweeps
    for (int i = 0; i < 7; i++)
      sweep3(tbl[i].func, tbl[i].gold, tbl[i].pass, tbl[i].err, tbl[i].first);

    // tables change mid-sweep and start is held high through DONE
    b3.func_tt = 8'hE8;
    b3.gold_tt = 8'hE9;
    b3.start   = 1'b1;
    e = cyc + 1;
    q3.push_back('{pass: 1'b0, err: 1, first: 0, done_cyc: e + 11});
    q3.push_back('{pass: 1'b0, err: 8, first: 0, done_cyc: e + 23});
    wait_to(e + 5);
    chk("mid_in_vec_3", b3.in_vec, 3);
    b3.func_tt = 8'h00;
    b3.gold_tt = 8'hFF;
    wait_to(e + 11);
    chk("mid_idle_gap_busy", b3.busy, 0);
    wait_to(e + 12);
    chk("mid_retrigger_busy", b3.busy, 1);
    b3.start = 1'b0;
    wait_all(40);

    // reset at sweep index 5
    b3.func_tt = 8'hE8;
    b3.gold_tt = 8'hE9;
    b3.start   = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    b3.start = 1'b0;
    wait_to(e + 7);
    chk("rst_mid_in_vec_5", b3.in_vec, 5);
    chk("rst_mid_err_before", b3.err_cnt, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_vec", b3.in_vec, 0);
    chk("rst_mid_f", b3.f, 0);
    chk("rst_mid_busy", b3.busy, 0);
    chk("rst_mid_done", b3.done, 0);
    chk("rst_mid_pass", b3.pass, 0);
    chk("rst_mid_err_cnt", b3.err_cnt, 0);
    chk("rst_mid_first_err_idx", b3.first_err_idx, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    sweep3(8'hE8, 8'hE8, 1'b1, 0, 0);

    // N_IN = 1
    b1.func_tt = 2'b10;
    b1.gold_tt = 2'b10;
    b1.start   = 1'b1;
    e = cyc + 1;
    q1.push_back('{pass: 1'b1, err: 0, first: 0, done_cyc: e + 5});
    @(negedge clk);
    b1.start = 1'b0;
    wait_all(20);
    b1.gold_tt = 2'b11;
    b1.start   = 1'b1;
    e = cyc + 1;
    q1.push_back('{pass: 1'b0, err: 1, first: 0, done_cyc: e + 5});
    @(negedge clk);
    b1.start = 1'b0;
    wait_all(20);

    // N_IN = 8
    for (int w = 0; w < 8; w++) b8.func_tt[32*w +: 32] = $urandom();
    b8.gold_tt = b8.func_tt;
    b8.start   = 1'b1;
    e = cyc + 1;
    q8.push_back('{pass: 1'b1, err: 0, first: 0, done_cyc: e + 259});
    @(negedge clk);
    b8.start = 1'b0;
    wait_all(300);
    b8.gold_tt[200] = ~b8.gold_tt[200];
    b8.start = 1'b1;
    e = cyc + 1;
    q8.push_back('{pass: 1'b0, err: 1, first: 200, done_cyc: e + 259});
    @(negedge clk);
    b8.start = 1'b0;
    wait_all(300);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q1.size() + q3.size() + q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
